// File: rtl/fpnew_pkg.sv
// Shared types and helpers for the iterative divide/square-root unit.
// Optional feature macro used by the unit: FPNEW_DIVSQRT_EARLY_READY_EN.
package fpnew_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } divsqrt_iter_state_e;

  // Number of restoring steps: one result bit per step, W+2 result bits.
  function automatic int unsigned divsqrt_iter_cycles(input int unsigned mant_width);
    return mant_width + 32'd2;
  endfunction

endpackage

// File: rtl/fpnew_divsqrt_iter_step.sv
// Single combinational radix-2 restoring step, shared by divide and square root.
module fpnew_divsqrt_iter_step #(
  parameter int unsigned MantWidth = 53
) (
  input  logic                 is_sqrt_i,
  input  logic [MantWidth+2:0] rem_i,
  input  logic [MantWidth+1:0] root_i,
  input  logic [1:0]           rad_bits_i,
  input  logic [MantWidth-1:0] divisor_i,
  output logic [MantWidth+2:0] rem_o,
  output logic                 q_bit_o
);

  localparam int unsigned RemW   = MantWidth + 3;
  localparam int unsigned TrialW = MantWidth + 5;

  logic [TrialW-1:0] div_rem, div_sub, div_diff;
  logic [TrialW-1:0] sq_trial, sq_sub, sq_diff;
  logic              div_ge, sq_ge;

  // Trial subtraction for both ops; the stored op type picks which one is used.
  always_comb begin
    div_rem  = {2'b00, rem_i};
    div_sub  = {5'b00000, divisor_i};
    div_ge   = (div_rem >= div_sub);
    div_diff = div_rem - div_sub;
    // Sqrt trial: (rem<<2 | next two radicand bits) - (root<<2 | 1).
    sq_trial = {rem_i, rad_bits_i};
    sq_sub   = {1'b0, root_i, 2'b01};
    sq_ge    = (sq_trial >= sq_sub);
    sq_diff  = sq_trial - sq_sub;
    q_bit_o  = 1'b0;
    rem_o    = '0;
    if (is_sqrt_i) begin
      q_bit_o = sq_ge;
      rem_o   = sq_ge ? RemW'(sq_diff) : RemW'(sq_trial);
    end else begin
      // Remainder stays below 2*divisor, so the shifted value always fits.
      q_bit_o = div_ge;
      rem_o   = div_ge ? RemW'(div_diff << 1) : RemW'(div_rem << 1);
    end
  end

endmodule

// File: rtl/fpnew_divsqrt_iter_unit.sv
// Iterative radix-2 mantissa divide / square-root engine, one result bit per cycle.
// Define FPNEW_DIVSQRT_EARLY_READY_EN to accept a new start in the DONE cycle.
module fpnew_divsqrt_iter_unit
  import fpnew_pkg::*;
#(
  parameter int unsigned MantWidth = 53
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 div_start_i,
  input  logic                 sqrt_start_i,
  input  logic [MantWidth:0]   op_a_i,
  input  logic [MantWidth-1:0] op_b_i,
  input  logic                 kill_i,
  output logic                 ready_o,
  output logic                 done_o,
  output logic [MantWidth+1:0] result_o,
  output logic                 sticky_o
);

  localparam int unsigned Iter = divsqrt_iter_cycles(MantWidth);
  localparam int unsigned CntW = $clog2(Iter + 1);
  localparam int unsigned RemW = MantWidth + 3;
  localparam int unsigned RadW = 2 * MantWidth + 4;

  divsqrt_iter_state_e state_q, state_d;

  logic [CntW-1:0]      cnt_q;
  logic                 is_sqrt_q;
  logic [RemW-1:0]      rem_q;
  logic [MantWidth+1:0] qr_q;
  logic [RadW-1:0]      rad_q;
  logic [MantWidth-1:0] b_q;
  logic                 a_nz_q;
  logic [MantWidth+1:0] result_q;
  logic                 sticky_q;

  logic [RemW-1:0] rem_nxt;
  logic            q_bit;
  logic            accept;
  logic            last_step;

  fpnew_divsqrt_iter_step #(
    .MantWidth(MantWidth)
  ) u_step (
    .is_sqrt_i (is_sqrt_q),
    .rem_i     (rem_q),
    .root_i    (qr_q),
    .rad_bits_i(rad_q[RadW-1 -: 2]),
    .divisor_i (b_q),
    .rem_o     (rem_nxt),
    .q_bit_o   (q_bit)
  );

  // Handshake outputs; none of them look at the start or operand inputs.
  always_comb begin
    done_o = (state_q == StDone) & ~kill_i;
`ifdef FPNEW_DIVSQRT_EARLY_READY_EN
    ready_o = (state_q == StIdle) | ((state_q == StDone) & ~kill_i);
`else
    ready_o = (state_q == StIdle);
`endif
    accept    = ready_o & (div_start_i | sqrt_start_i) & ~kill_i;
    last_step = (state_q == StBusy) && (cnt_q == CntW'(Iter - 1));
  end

  // Next-state logic; kill overrides every transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StBusy;
      StBusy: if (last_step) state_d = StDone;
      StDone: state_d = accept ? StBusy : StIdle;
      default: state_d = StIdle;
    endcase
    if (kill_i) state_d = StIdle;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Operand latch, iteration datapath and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      is_sqrt_q <= 1'b0;
      rem_q     <= '0;
      qr_q      <= '0;
      rad_q     <= '0;
      b_q       <= '0;
      a_nz_q    <= 1'b0;
      result_q  <= '0;
      sticky_q  <= 1'b0;
    end else if (state_q == StBusy && !kill_i) begin
      rem_q <= rem_nxt;
      qr_q  <= {qr_q[MantWidth:0], q_bit};
      rad_q <= rad_q << 2;
      cnt_q <= cnt_q + CntW'(1);
      if (last_step) begin
        result_q <= {qr_q[MantWidth:0], q_bit};
        // A zero divisor never reduces the remainder; report the dividend instead.
        sticky_q <= (!is_sqrt_q && b_q == '0) ? a_nz_q : (rem_nxt != '0);
      end
    end else if (accept) begin
      is_sqrt_q <= ~div_start_i;
      rem_q     <= div_start_i ? {2'b00, op_a_i} : '0;
      qr_q      <= '0;
      rad_q     <= {op_a_i, {(MantWidth + 3){1'b0}}};
      b_q       <= op_b_i;
      a_nz_q    <= (op_a_i != '0);
      cnt_q     <= '0;
    end
  end

  assign result_o = result_q;
  assign sticky_o = sticky_q;

endmodule

// File: tb/tb_fpnew_divsqrt_iter_unit.sv
// Scoreboard bench for the iterative divide/square-root unit (W=24).
module tb_fpnew_divsqrt_iter_unit;

  localparam int W = 24;
  localparam int Lat = W + 3;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          div_start_i = 1'b0;
  logic          sqrt_start_i = 1'b0;
  logic [W:0]    op_a_i = '0;
  logic [W-1:0]  op_b_i = '0;
  logic          kill_i = 1'b0;
  logic          ready_o, done_o, sticky_o;
  logic [W+1:0]  result_o;

  typedef struct {
    logic [W+1:0] res;
    logic         st;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  fpnew_divsqrt_iter_unit #(
    .MantWidth(W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .div_start_i (div_start_i),
    .sqrt_start_i(sqrt_start_i),
    .op_a_i      (op_a_i),
    .op_b_i      (op_b_i),
    .kill_i      (kill_i),
    .ready_o     (ready_o),
    .done_o      (done_o),
    .result_o    (result_o),
    .sticky_o    (sticky_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (done_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_o=1, expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", 64'(result_o), 64'(e.res));
        chk("sticky", 64'(sticky_o), 64'(e.st));
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for ready, drives one start cycle; n = cycle in which the start is sampled.
  task automatic issue(input logic dv, input logic sq, input logic [W:0] a,
                       input logic [W-1:0] b, input logic push, input logic [W+1:0] er,
                       input logic es, output int n);
    int k;
    exp_t e;
    k = 0;
    while (!ready_o && k < 200) begin
      step();
      k++;
    end
    if (!ready_o) chk("ready_timeout", 64'(ready_o), 64'd1);
    n = cyc;
    div_start_i = dv;
    sqrt_start_i = sq;
    op_a_i = a;
    op_b_i = b;
    if (push) begin
      e.res = er;
      e.st  = es;
      e.cyc = n + Lat;
      exp_q.push_back(e);
    end
    step();
    div_start_i = 1'b0;
    sqrt_start_i = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      step();
      k++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (3) step();
  endtask

  initial begin
    int n;
    repeat (3) step();
    rst_i = 1'b0;
    chk("reset_ready", 64'(ready_o), 64'd1);
    chk("reset_done", 64'(done_o), 64'd0);
    chk("reset_result", 64'(result_o), 64'd0);
    chk("reset_sticky", 64'(sticky_o), 64'd0);

    // Basic divides and square roots.
    issue(1, 0, 25'h0C00000, 24'hC00000 >> 0 == 24'hC00000 ? 24'h800000 : 24'h0, 1,
          26'h3000000, 1'b0, n);
    chk("busy_not_ready", 64'(ready_o), 64'd0);
    drain();
    issue(1, 0, 25'h0800000, 24'hC00000, 1, 26'h1555555, 1'b1, n);
    drain();
    issue(0, 1, 25'h1000000, 24'h000000, 1, 26'h2D413CC, 1'b1, n);
    drain();
    issue(0, 1, 25'h0800000, 24'h123456, 1, 26'h2000000, 1'b0, n);
    drain();
    issue(1, 0, 25'h0E00000, 24'hE00000, 1, 26'h2000000, 1'b0, n);
    drain();
    // Both starts high: division wins.
    issue(1, 1, 25'h0C00000, 24'h800000, 1, 26'h3000000, 1'b0, n);
    drain();
    // Zero divisor: all-ones quotient, sticky from the dividend.
    issue(1, 0, 25'h0C00000, 24'h000000, 1, 26'h3FFFFFF, 1'b1, n);
    drain();

    // Kill in BUSY cycle 10.
    issue(1, 0, 25'h0C00000, 24'h800000, 0, '0, 1'b0, n);
    while (cyc < n + 10) step();
    kill_i = 1'b1;
    step();
    kill_i = 1'b0;
    chk("kill_ready", 64'(ready_o), 64'd1);
    chk("kill_done", 64'(done_o), 64'd0);
    repeat (30) step();
    issue(1, 0, 25'h0800000, 24'hC00000, 1, 26'h1555555, 1'b1, n);
    drain();

    // Kill in the DONE cycle suppresses done_o.
    issue(1, 0, 25'h0C00000, 24'h800000, 0, '0, 1'b0, n);
    while (cyc < n + Lat) step();
    kill_i = 1'b1;
    #1;
    chk("kill_done_cycle", 64'(done_o), 64'd0);
    step();
    kill_i = 1'b0;
    chk("kill_done_ready", 64'(ready_o), 64'd1);
    repeat (3) step();

    // Reset mid-BUSY.
    issue(1, 0, 25'h0800000, 24'hC00000, 0, '0, 1'b0, n);
    while (cyc < n + 5) step();
    rst_i = 1'b1;
    step();
    chk("midrst_ready", 64'(ready_o), 64'd1);
    chk("midrst_done", 64'(done_o), 64'd0);
    chk("midrst_result", 64'(result_o), 64'd0);
    chk("midrst_sticky", 64'(sticky_o), 64'd0);
    rst_i = 1'b0;
    repeat (35) step();

    // Start presented in the DONE cycle.
    issue(1, 0, 25'h0C00000, 24'h800000, 1, 26'h3000000, 1'b0, n);
    while (cyc < n + Lat) step();
    div_start_i = 1'b1;
    op_a_i = 25'h0800000;
    op_b_i = 24'hC00000;
`ifdef FPNEW_DIVSQRT_EARLY_READY_EN
    chk("done_cycle_ready", 64'(ready_o), 64'd1);
    begin
      exp_t e;
      e.res = 26'h1555555;
      e.st  = 1'b1;
      e.cyc = cyc + Lat;
      exp_q.push_back(e);
    end
`else
    chk("done_cycle_ready", 64'(ready_o), 64'd0);
`endif
    step();
    div_start_i = 1'b0;
    drain();
    repeat (35) step();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t, expected completion earlier", $time);
    $fatal(1);
  end

endmodule
